// File: rtl/seven_seg_capture_if.sv
// Scanned seven-segment bus as seen by a capture/loopback checker.
// The display side drives Bit/SEG; the capture side returns the reconstructed digits and event pulses.
interface seven_seg_capture_if #(
  parameter int DIGITS = 8
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]   Bit;
  logic [7:0]          SEG;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   valid;
  logic                upd;
  logic [IW-1:0]       upd_idx;
  logic                bad_pat;
  logic                bad_sel;
  logic                scan_wrap;

  modport master (
    output Bit, SEG,
    input  digits, dp, valid, upd, upd_idx, bad_pat, bad_sel, scan_wrap
  );

  modport slave (
    input  Bit, SEG,
    output digits, dp, valid, upd, upd_idx, bad_pat, bad_sel, scan_wrap
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Receiver for a multiplexed seven-segment scan: debounces {Bit,SEG}, decodes hex glyphs
// per digit and flags illegal glyphs, multi-digit selects and scan wrap-around.
//
// state  | meaning
// WAIT   | nothing pending since reset
// SETTLE | new value seen, counting identical samples down to terminal count
// LOCKED | current value accepted, waiting for a change
module seven_seg_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  seven_seg_capture_if.slave bus
);

  localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         SW   = DIGITS + 8;
  localparam logic [7:0] LOAD = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [SW-1:0] samp_q;
  logic [SW-1:0] samp_in;
  logic          diff;
  logic          accept;

  assign samp_in = {bus.Bit, bus.SEG};
  assign diff    = (samp_in != samp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      samp_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_in;
    end
  end

  // Counter holds the number of identical samples still needed; zero means the held value is stable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      WAIT: begin
        if (diff) begin
          state_d = SETTLE;
          cnt_d   = LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          accept = 1'b1;
          if (diff) begin
            state_d = SETTLE;
            cnt_d   = LOAD;
          end else begin
            state_d = LOCKED;
          end
        end else if (diff) begin
          cnt_d = LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOCKED: begin
        if (diff) begin
          state_d = SETTLE;
          cnt_d   = LOAD;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  function automatic logic [4:0] glyph(input logic [6:0] s);
    case (s)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [DIGITS-1:0] sel;
  logic [7:0]        seg_acc;
  logic              sel_any;
  logic              sel_multi;
  logic [IW-1:0]     sel_idx;
  logic              hit;
  logic [3:0]        nib;

  assign sel       = ~samp_q[SW-1:8];
  assign seg_acc   = samp_q[7:0];
  assign sel_any   = |sel;
  assign sel_multi = (sel & (sel - 1'b1)) != '0;
  assign {hit, nib} = glyph(seg_acc[6:0]);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   valid_q;
  logic                upd_q;
  logic [IW-1:0]       upd_idx_q;
  logic                bad_pat_q;
  logic                bad_sel_q;
  logic                wrap_q;
  logic [IW-1:0]       prev_idx_q;
  logic                first_q;

  // The first commit after reset has no meaningful predecessor, so it never reports a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q   <= '0;
      dp_q       <= '0;
      valid_q    <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
      bad_pat_q  <= 1'b0;
      bad_sel_q  <= 1'b0;
      wrap_q     <= 1'b0;
      prev_idx_q <= IW'(DIGITS - 1);
      first_q    <= 1'b1;
    end else begin
      upd_q     <= 1'b0;
      bad_pat_q <= 1'b0;
      bad_sel_q <= 1'b0;
      wrap_q    <= 1'b0;
      if (accept && sel_any) begin
        if (sel_multi) begin
          bad_sel_q <= 1'b1;
        end else if (hit) begin
          digits_q[4*sel_idx +: 4] <= nib;
          dp_q[sel_idx]            <= ~seg_acc[7];
          valid_q[sel_idx]         <= 1'b1;
          upd_q                    <= 1'b1;
          upd_idx_q                <= sel_idx;
          wrap_q                   <= ~first_q && (sel_idx <= prev_idx_q);
          prev_idx_q               <= sel_idx;
          first_q                  <= 1'b0;
        end else begin
          valid_q[sel_idx] <= 1'b0;
          bad_pat_q        <= 1'b1;
        end
      end
    end
  end

  assign bus.digits    = digits_q;
  assign bus.dp        = dp_q;
  assign bus.valid     = valid_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = upd_idx_q;
  assign bus.bad_pat   = bad_pat_q;
  assign bus.bad_sel   = bad_sel_q;
  assign bus.scan_wrap = wrap_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans, glitches, illegal glyphs/selects, wrap and async reset.
module tb_seven_seg_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seven_seg_capture_if #(.DIGITS(8)) bus ();

  seven_seg_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  int n_upd, n_bad_pat, n_bad_sel, n_wrap, lat, zero_write;
  logic [2:0] last_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_upd = 0; n_bad_pat = 0; n_bad_sel = 0; n_wrap = 0;
    lat = 0; zero_write = 0; last_idx = '0;
  endtask

  // Drive a value for n edges, tallying every pulse seen just after each edge.
  task automatic hold(input logic [7:0] b, input logic [7:0] s, input int n);
    bus.Bit = b;
    bus.SEG = s;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (bus.upd) begin
        n_upd++;
        last_idx = bus.upd_idx;
        lat = i;
        if (bus.upd_idx == 3'd0 && bus.digits[3:0] == 4'h0) zero_write++;
      end
      if (bus.bad_pat)   n_bad_pat++;
      if (bus.bad_sel)   n_bad_sel++;
      if (bus.scan_wrap) n_wrap++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_bit [4] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] t1_seg [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
  logic [2:0] t1_idx [4] = '{3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    bus.Bit = 8'hFF;
    bus.SEG = 8'hFF;
    clr();

    // reset release
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",  bus.digits,    32'h0);
    check("rst_dp",      bus.dp,        8'h00);
    check("rst_valid",   bus.valid,     8'h00);
    check("rst_pulses",  {bus.upd, bus.bad_pat, bus.bad_sel, bus.scan_wrap}, 4'b0000);
    check("rst_upd_idx", bus.upd_idx,   3'd0);
    rst = 1'b0;

    // scan 3,2,1,0 showing 1,2,3,4
    for (int j = 0; j < 4; j++) begin
      clr();
      hold(t1_bit[j], t1_seg[j], 8);
      check($sformatf("scan%0d_upd_cnt", j), n_upd, 1);
      check($sformatf("scan%0d_upd_idx", j), last_idx, t1_idx[j]);
      check($sformatf("scan%0d_latency", j), lat, 5);
    end
    check("scan_digits", bus.digits[15:0], 16'h1234);
    check("scan_valid",  bus.valid, 8'h0F);

    // glitch: 0 held only 2 cycles, then 1
    clr();
    hold(8'hFE, 8'hC0, 2);
    hold(8'hFE, 8'hF9, 8);
    check("glitch_upd_cnt", n_upd, 1);
    check("glitch_digit0",  bus.digits[3:0], 4'h1);
    check("glitch_no_zero", zero_write, 0);

    // illegal glyph on digit 2 after committing 5
    clr();
    hold(8'hFB, 8'h92, 8);
    check("pat_commit5", bus.digits[11:8], 4'h5);
    clr();
    hold(8'hFB, 8'h7F, 6);
    check("pat_bad_cnt",  n_bad_pat, 1);
    check("pat_no_upd",   n_upd, 0);
    check("pat_valid2",   bus.valid[2], 1'b0);
    check("pat_digit2",   bus.digits[11:8], 4'h5);

    // two digits selected, then blanking
    clr();
    hold(8'hFC, 8'hC0, 6);
    hold(8'hFF, 8'hC0, 6);
    check("sel_bad_cnt", n_bad_sel, 1);
    check("sel_no_upd",  n_upd, 0);
    check("sel_no_pat",  n_bad_pat, 0);
    check("sel_valid",   bus.valid, 8'h0B);

    // wrap and dp: fresh reset, ascending scan of 8 with dp lit, then digit 0 again
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    for (int k = 0; k < 8; k++) begin
      hold(~(8'h01 << k), 8'h00, 6);
    end
    check("wrap_first_pass", n_wrap, 0);
    check("wrap_upd_cnt",    n_upd, 8);
    clr();
    hold(8'hFE, 8'h00, 6);
    check("wrap_second_k0", n_wrap, 1);
    check("wrap_idx",       last_idx, 3'd0);
    check("wrap_dp",        bus.dp, 8'hFF);
    check("wrap_digits",    bus.digits, 32'h88888888);
    check("wrap_valid",     bus.valid, 8'hFF);

    // async reset while settling (count 2)
    clr();
    hold(8'hFD, 8'hC0, 2);
    #3;
    rst = 1'b1;
    #1;
    check("arst_digits",  bus.digits,  32'h0);
    check("arst_dp",      bus.dp,      8'h00);
    check("arst_valid",   bus.valid,   8'h00);
    check("arst_upd_idx", bus.upd_idx, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    hold(8'hFD, 8'hC0, 4);
    check("arst_no_early_upd", n_upd, 0);
    hold(8'hFD, 8'hC0, 1);
    check("arst_settled_upd", n_upd, 1);
    check("arst_settled_idx", last_idx, 3'd1);
    check("arst_valid_after", bus.valid, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
